// File: rtl/align_scheduler.sv
// align_scheduler: drives one query-vs-reference job through the systolic array, chunk by chunk.
// Latency: start->new_seq 1 cycle, fetch address->S/T 2 cycles; no backpressure, each chunk waits on the busy fall.
module align_scheduler #(
    parameter int N             = 64,
    parameter int LOG_N         = 6,
    parameter int BP_WIDTH      = 2,
    parameter int ADDRESS_WIDTH = 10,
    parameter int MEM_AMOUNT    = 4
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] q_len,
    input  logic [ADDRESS_WIDTH-1:0] r_len,
    output logic [ADDRESS_WIDTH-1:0] q_addr,
    input  logic [BP_WIDTH-1:0]      q_data,
    output logic [ADDRESS_WIDTH-1:0] r_addr,
    input  logic [BP_WIDTH-1:0]      r_data,
    output logic [BP_WIDTH-1:0]      S,
    output logic [BP_WIDTH-1:0]      T,
    output logic                     s_update,
    output logic                     valid,
    output logic                     ack,
    output logic                     new_seq,
    output logic [LOG_N-1:0]         PE_end,
    output logic                     use_s1,
    input  logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [2:0] {IDLE, INIT, ACK, LOAD, STREAM, DRAIN, NEXT} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   chunk, chunk_nxt, chunks_r;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [AW-1:0]   q_len_r, r_len_r;
    logic [AW:0]     chunks_req;
    logic            len_ok, last_chunk, last_nxt, job_end, err_nxt;
    logic [AW-1:0]   q_addr_nxt;
    logic [LOG_N-1:0] pe_last;
    logic            seen;
    logic            q_issue, q_zero, q_pend, q_pend_zero;
    logic            t_issue, t_pend;

    assign chunks_req = ({1'b0, q_len} + (AW+1)'(N-1)) >> LOG_N;
    assign len_ok     = (q_len != '0) && (r_len != '0) && (chunks_req <= (AW+1)'(MEM_AMOUNT));
    assign last_chunk = (chunk + AW'(1)) == chunks_r;
    assign last_nxt   = (chunk_nxt + AW'(1)) == chunks_r;
    assign pe_last    = q_len_r[LOG_N-1:0] - LOG_N'(1);
    assign err_nxt    = (state == IDLE) && start && !abort && !len_ok;

    always_comb begin
        state_nxt = state;
        chunk_nxt = chunk;
        case (state)
            IDLE: begin
                if (start && len_ok) begin
                    state_nxt = INIT;
                    chunk_nxt = '0;
                end
            end
            INIT:   state_nxt = ACK;
            ACK:    state_nxt = LOAD;
            LOAD:   if (cnt == AW'(N-1)) state_nxt = STREAM;
            STREAM: if (cnt == r_len_r - AW'(1)) state_nxt = DRAIN;
            // a busy level already high on entry counts as the rise
            DRAIN:  if (seen && !busy) state_nxt = NEXT;
            NEXT: begin
                if (!last_chunk) begin
                    chunk_nxt = chunk + AW'(1);
                    state_nxt = ACK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign cnt_nxt    = ((state_nxt == state) && (state == LOAD || state == STREAM)) ? cnt + AW'(1) : '0;
    assign q_addr_nxt = (chunk_nxt << LOG_N) + cnt_nxt;
    assign job_end    = (state == DRAIN) && (state_nxt == NEXT) && last_chunk;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            chunk       <= '0;
            chunks_r    <= '0;
            cnt         <= '0;
            q_len_r     <= '0;
            r_len_r     <= '0;
            seen        <= 1'b0;
            q_issue     <= 1'b0;
            q_zero      <= 1'b0;
            q_pend      <= 1'b0;
            q_pend_zero <= 1'b0;
            t_issue     <= 1'b0;
            t_pend      <= 1'b0;
            q_addr      <= '0;
            r_addr      <= '0;
            S           <= '0;
            T           <= '0;
            s_update    <= 1'b0;
            valid       <= 1'b0;
            ack         <= 1'b0;
            new_seq     <= 1'b0;
            PE_end      <= LOG_N'(N-1);
            use_s1      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            chunk <= chunk_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && state_nxt == INIT) begin
                q_len_r  <= q_len;
                r_len_r  <= r_len;
                chunks_r <= chunks_req[AW-1:0];
            end
            seen <= (state == DRAIN) && (state_nxt == DRAIN) && (seen || busy);

            // query fetch: address, then data, then S/s_update
            q_issue     <= (state_nxt == LOAD);
            q_zero      <= (state_nxt == LOAD) && (q_addr_nxt >= q_len_r);
            q_addr      <= (state_nxt == LOAD) ? q_addr_nxt : '0;
            q_pend      <= q_issue && !abort;
            q_pend_zero <= q_zero;
            s_update    <= q_pend && !abort;
            S           <= (q_pend && !q_pend_zero && !abort) ? q_data : '0;

            // reference stream: same two-stage alignment for T/valid
            t_issue <= (state_nxt == STREAM);
            r_addr  <= (state_nxt == STREAM) ? cnt_nxt : '0;
            t_pend  <= t_issue && !abort;
            valid   <= t_pend && !abort;
            T       <= (t_pend && !abort) ? r_data : '0;

            // ack covers the ACK cycle, then the stream until its last valid beat
            ack <= !abort && ((state_nxt == ACK) || (state_nxt == STREAM) || t_issue || t_pend);

            new_seq <= (state_nxt == INIT);
            if (state_nxt == ACK) PE_end <= last_nxt ? pe_last : LOG_N'(N-1);
            done    <= job_end;
            if (job_end) use_s1 <= !use_s1;
            err     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_align_scheduler.sv
// Directed bench for align_scheduler: table of jobs plus abort, start/abort and mid-job reset sequences.
module tb_align_scheduler;
    localparam int N = 64, LOG_N = 6, BPW = 2, AW = 10, MEM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_i, start, abort, busy;
    logic [AW-1:0]  q_len, r_len, q_addr, r_addr;
    logic [BPW-1:0] q_data, r_data, S, T;
    logic           s_update, valid, ack, new_seq, use_s1, done, err;
    logic [LOG_N-1:0] PE_end;

    align_scheduler #(.N(N), .LOG_N(LOG_N), .BP_WIDTH(BPW), .ADDRESS_WIDTH(AW), .MEM_AMOUNT(MEM)) dut (
        .clk(clk), .reset_i(reset_i), .start(start), .abort(abort),
        .q_len(q_len), .r_len(r_len), .q_addr(q_addr), .q_data(q_data),
        .r_addr(r_addr), .r_data(r_data), .S(S), .T(T), .s_update(s_update),
        .valid(valid), .ack(ack), .new_seq(new_seq), .PE_end(PE_end),
        .use_s1(use_s1), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [1:0] qb(input int a);
        return 2'(a ^ (a >> 2));
    endfunction
    function automatic logic [1:0] rb(input int a);
        return 2'(a * 3 + (a >> 3));
    endfunction

    // sequence buffers with one-cycle read latency
    always @(posedge clk) begin
        q_data <= qb(int'(q_addr));
        r_data <= rb(int'(r_addr));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // array model: busy rises with valid and falls a few cycles after the stream ends
    initial begin
        int tail;
        busy = 1'b0;
        tail = 0;
        forever begin
            @(posedge clk);
            #1;
            if (valid) begin
                busy = 1'b1;
                tail = 4;
            end else if (busy) begin
                if (tail == 0) busy = 1'b0;
                else tail--;
            end
        end
    end

    typedef struct {
        int ns; int ackc; int ackg; int s; int sg; int v; int vg;
        int dn; int er; int sm; int tm; int pm;
    } cnt_t;

    cnt_t mon = '{default: 0};
    int   s_k = 0, t_k = 0, fall_cyc = 0, done_cyc = 0, ns_cyc = 0, err_cyc = 0;
    logic ack_p = 1'b0, s_p = 1'b0, v_p = 1'b0, busy_p = 1'b0;
    int   job_q_len = 0, job_r_len = 1, job_chunks = 0, job_pe_last = 0;

    always @(negedge clk) begin
        ack_p  <= ack;
        s_p    <= s_update;
        v_p    <= valid;
        busy_p <= busy;
        if (busy_p && !busy) fall_cyc <= cyc;
        if (ack) mon.ackc <= mon.ackc + 1;
        if (ack && !ack_p) mon.ackg <= mon.ackg + 1;
        if (s_update && !s_p) mon.sg <= mon.sg + 1;
        if (valid && !v_p) mon.vg <= mon.vg + 1;
        if (done) begin
            mon.dn   <= mon.dn + 1;
            done_cyc <= cyc;
        end
        if (err) begin
            mon.er  <= mon.er + 1;
            err_cyc <= cyc;
        end
        if (s_update) begin
            mon.s <= mon.s + 1;
            if (S !== ((s_k < job_q_len) ? qb(s_k) : 2'd0)) mon.sm <= mon.sm + 1;
            if (PE_end !== ((s_k / N == job_chunks - 1) ? LOG_N'(job_pe_last) : LOG_N'(N-1)))
                mon.pm <= mon.pm + 1;
            s_k <= s_k + 1;
        end
        if (valid) begin
            mon.v <= mon.v + 1;
            if (T !== rb(t_k % job_r_len)) mon.tm <= mon.tm + 1;
            t_k <= t_k + 1;
        end
        if (new_seq) begin
            mon.ns <= mon.ns + 1;
            ns_cyc <= cyc;
            s_k    <= 0;
            t_k    <= 0;
        end
    end

    int n_chk = 0, n_fail = 0;
    int s_cyc = 0;
    logic exp_use_s1 = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_q_addr"}, int'(q_addr), 0);
        chk({tag, "_r_addr"}, int'(r_addr), 0);
        chk({tag, "_S"}, int'(S), 0);
        chk({tag, "_T"}, int'(T), 0);
        chk({tag, "_s_update"}, int'(s_update), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_new_seq"}, int'(new_seq), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_PE_end"}, int'(PE_end), N - 1);
        chk({tag, "_use_s1"}, int'(use_s1), 0);
    endtask

    task automatic pulse_start(input int ql, input int rl, input logic with_abort);
        @(posedge clk);
        #1;
        q_len = AW'(ql);
        r_len = AW'(rl);
        start = 1'b1;
        abort = with_abort;
        s_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct { int ql; int rl; bit e; int ch; int pel; } vec_t;

    task automatic set_job(input vec_t v);
        job_q_len   = v.ql;
        job_r_len   = (v.rl == 0) ? 1 : v.rl;
        job_chunks  = v.ch;
        job_pe_last = v.pel;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        cnt_t b;
        bit   ended;
        b = mon;
        set_job(v);
        pulse_start(v.ql, v.rl, 1'b0);
        ended = 1'b0;
        for (int i = 0; i < 8000 && !ended; i++) begin
            @(negedge clk);
            if (mon.dn != b.dn || mon.er != b.er) ended = 1'b1;
        end
        repeat (12) @(negedge clk);
        if (!v.e) exp_use_s1 = !exp_use_s1;
        chk({nm, "_ended"}, int'(ended), 1);
        chk({nm, "_err"}, mon.er - b.er, v.e ? 1 : 0);
        chk({nm, "_new_seq"}, mon.ns - b.ns, v.e ? 0 : 1);
        chk({nm, "_done"}, mon.dn - b.dn, v.e ? 0 : 1);
        chk({nm, "_s_cycles"}, mon.s - b.s, v.ch * N);
        chk({nm, "_s_groups"}, mon.sg - b.sg, v.ch);
        chk({nm, "_v_cycles"}, mon.v - b.v, v.ch * v.rl);
        chk({nm, "_v_groups"}, mon.vg - b.vg, v.ch);
        chk({nm, "_ack_groups"}, mon.ackg - b.ackg, 2 * v.ch);
        chk({nm, "_ack_cycles"}, mon.ackc - b.ackc, v.ch * (v.rl + 3));
        chk({nm, "_S_data"}, mon.sm - b.sm, 0);
        chk({nm, "_T_data"}, mon.tm - b.tm, 0);
        chk({nm, "_PE_end_run"}, mon.pm - b.pm, 0);
        chk({nm, "_use_s1"}, int'(use_s1), int'(exp_use_s1));
        if (!v.e) begin
            chk({nm, "_PE_end_last"}, int'(PE_end), v.pel);
            chk({nm, "_new_seq_lat"}, ns_cyc - s_cyc, 1);
            chk({nm, "_done_lat"}, done_cyc - fall_cyc, 1);
        end else begin
            chk({nm, "_err_lat"}, err_cyc - s_cyc, 1);
        end
    endtask

    initial begin
        vec_t vecs[8];
        cnt_t b;
        bit   hit;

        vecs[0] = '{ql: 64,  rl: 100, e: 0, ch: 1, pel: 63};
        vecs[1] = '{ql: 130, rl: 20,  e: 0, ch: 3, pel: 1};
        vecs[2] = '{ql: 0,   rl: 10,  e: 1, ch: 0, pel: 0};
        vecs[3] = '{ql: 300, rl: 10,  e: 1, ch: 0, pel: 0};
        vecs[4] = '{ql: 10,  rl: 0,   e: 1, ch: 0, pel: 0};
        vecs[5] = '{ql: 256, rl: 5,   e: 0, ch: 4, pel: 63};
        vecs[6] = '{ql: 1,   rl: 3,   e: 0, ch: 1, pel: 0};
        vecs[7] = '{ql: 200, rl: 1,   e: 0, ch: 4, pel: 7};

        reset_i = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        q_len   = '0;
        r_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_rst("por");
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        check_rst("idle");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // abort in the middle of chunk 1's stream
        b = mon;
        set_job(vecs[1]);
        pulse_start(130, 20, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (mon.v - b.v >= 25) hit = 1'b1;
        end
        chk("abort_reached_stream", int'(hit), 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid_drop", int'(valid), 0);
        chk("abort_ack_drop", int'(ack), 0);
        repeat (30) @(negedge clk);
        chk("abort_no_done", mon.dn - b.dn, 0);
        chk("abort_use_s1", int'(use_s1), int'(exp_use_s1));
        run_vec(vecs[0], "after_abort");

        // start and abort together in IDLE
        b = mon;
        pulse_start(64, 10, 1'b1);
        repeat (10) @(negedge clk);
        chk("start_abort_new_seq", mon.ns - b.ns, 0);
        chk("start_abort_ack", mon.ackg - b.ackg, 0);
        chk("start_abort_err", mon.er - b.er, 0);

        // reset pulse while the query is loading
        b = mon;
        set_job(vecs[0]);
        pulse_start(64, 10, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (q_addr == AW'(5)) hit = 1'b1;
        end
        chk("rst_reached_load", int'(hit), 1);
        reset_i = 1'b0;
        #1;
        check_rst("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b1;
        exp_use_s1 = 1'b0;
        repeat (10) @(negedge clk);
        check_rst("rst_hold");
        chk("rst_no_done", mon.dn - b.dn, 0);
        run_vec(vecs[6], "after_rst");

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule
